// File: rtl/tmds_encoder_8b10b_if.sv
// rtl/tmds_encoder_8b10b_if.sv - per-channel TMDS encoder input/output bundle
//
// Purpose: groups the period mode, payload inputs and the encoded codeword
//          of one TMDS lane so the encoder and its source share one port.
// Signals:
//   mode_i  [1:0]  period: 00 control, 01 video, 10 data island, 11 guard band
//   dat_i   [7:0]  pixel byte (video period)
//   ctrl_i  [1:0]  {C1,C0} control bits (control period)
//   aux_i   [3:0]  TERC4 nibble (data island period)
//   tmds_o  [9:0]  registered codeword, bit 0 serialized first
// Modports:
//   master  pixel source side (drives mode/dat/ctrl/aux, reads tmds_o)
//   slave   encoder side (reads mode/dat/ctrl/aux, drives tmds_o)

interface tmds_encoder_8b10b_if;
    logic [1:0] mode_i;
    logic [7:0] dat_i;
    logic [1:0] ctrl_i;
    logic [3:0] aux_i;
    logic [9:0] tmds_o;

    modport master (
        output mode_i,
        output dat_i,
        output ctrl_i,
        output aux_i,
        input  tmds_o
    );

    modport slave (
        input  mode_i,
        input  dat_i,
        input  ctrl_i,
        input  aux_i,
        output tmds_o
    );
endinterface

// File: rtl/tmds_encoder_8b10b.sv
// rtl/tmds_encoder_8b10b.sv - two-stage DC-balanced TMDS encoder for one lane
//
// Purpose: turns pixel bytes, control bits, TERC4 nibbles and guard bands
//          into 10-bit TMDS codewords, one per pixel clock, fixed 2-cycle
//          latency, feeding the 10:1 serializer directly.
// Parameters:
//   CHANNEL  lane index 0..2; lane 1 uses guard code 10'h133, others 10'h2CC
// Ports:
//   ref_clk_i  pixel clock, all state on its rising edge
//   rst_n      asynchronous active-low reset
//   bus        tmds_encoder_8b10b_if.slave (mode_i, dat_i, ctrl_i, aux_i, tmds_o)
// Configuration:
//   HDMI_TERC4_EN  when defined, mode 10 emits TERC4(aux_i); otherwise mode 10
//                  is encoded as a control period and aux_i is ignored.

module tmds_encoder_8b10b #(
    parameter int CHANNEL = 0
) (
    input  logic                  ref_clk_i,
    input  logic                  rst_n,
    tmds_encoder_8b10b_if.slave   bus
);

    localparam logic [1:0] MODE_CTRL  = 2'b00;
    localparam logic [1:0] MODE_VIDEO = 2'b01;
    localparam logic [1:0] MODE_ISLE  = 2'b10;
    localparam logic [1:0] MODE_GUARD = 2'b11;

    localparam logic [9:0] GUARD_CODE = (CHANNEL == 1) ? 10'h133 : 10'h2CC;
    localparam logic [9:0] RESET_CODE = 10'h354;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    function automatic logic [9:0] ctrl_code(input logic [1:0] c);
        logic [9:0] w;
        case (c)
            2'b00:   w = 10'h354;
            2'b01:   w = 10'h0AB;
            2'b10:   w = 10'h154;
            default: w = 10'h2AB;
        endcase
        return w;
    endfunction

`ifdef HDMI_TERC4_EN
    function automatic logic [9:0] terc4_code(input logic [3:0] a);
        logic [9:0] w;
        case (a)
            4'h0:    w = 10'h29C;
            4'h1:    w = 10'h263;
            4'h2:    w = 10'h2E4;
            4'h3:    w = 10'h2E2;
            4'h4:    w = 10'h171;
            4'h5:    w = 10'h11E;
            4'h6:    w = 10'h18E;
            4'h7:    w = 10'h13C;
            4'h8:    w = 10'h2CC;
            4'h9:    w = 10'h139;
            4'hA:    w = 10'h19C;
            4'hB:    w = 10'h2C6;
            4'hC:    w = 10'h28E;
            4'hD:    w = 10'h271;
            4'hE:    w = 10'h163;
            default: w = 10'h2C3;
        endcase
        return w;
    endfunction
`endif

    // Stage-1 registers
    logic [8:0]        r_q_m;
    logic [1:0]        r_mode;
    logic [1:0]        r_ctrl;
`ifdef HDMI_TERC4_EN
    logic [3:0]        r_aux;
`endif

    // Stage-2 registers
    logic [9:0]        r_tmds;
    logic signed [4:0] r_cnt;

    // Stage-1 combinational
    logic [3:0]        w_n1d;
    logic              w_use_xnor;
    logic [8:0]        w_q_m;

    // Stage-2 combinational
    logic [3:0]        w_n1;
    logic signed [4:0] w_diff;
    logic              w_q8;
    logic [9:0]        w_tmds;
    logic signed [4:0] w_cnt_next;

    // Transition minimisation: XNOR chain for byte-heavy-in-ones inputs so the
    // intermediate word has fewer transitions; q_m[8] records which chain ran.
    always_comb begin
        logic [8:0] v_q;
        w_n1d      = popcount8(bus.dat_i);
        w_use_xnor = (w_n1d > 4'd4) || ((w_n1d == 4'd4) && !bus.dat_i[0]);
        v_q        = '0;
        v_q[0]     = bus.dat_i[0];
        for (int i = 1; i < 8; i++) begin
            v_q[i] = w_use_xnor ? ~(v_q[i-1] ^ bus.dat_i[i])
                                :  (v_q[i-1] ^ bus.dat_i[i]);
        end
        v_q[8]     = ~w_use_xnor;
        w_q_m      = v_q;
    end

    // w_diff = n1 - n0 of q_m[7:0] = 2*n1 - 8; 5-bit wrap keeps +8 correct.
    always_comb begin
        w_n1   = popcount8(r_q_m[7:0]);
        w_diff = $signed({w_n1, 1'b0}) - 5'sd8;
        w_q8   = r_q_m[8];
    end

    // DC balancing and period selection. Every non-video period clears the
    // running disparity so the next video word starts balanced.
    always_comb begin
        w_tmds     = ctrl_code(r_ctrl);
        w_cnt_next = 5'sd0;
        case (r_mode)
            MODE_VIDEO: begin
                if ((r_cnt == 5'sd0) || (w_diff == 5'sd0)) begin
                    w_tmds     = {~w_q8, w_q8, (w_q8 ? r_q_m[7:0] : ~r_q_m[7:0])};
                    w_cnt_next = w_q8 ? (r_cnt + w_diff) : (r_cnt - w_diff);
                end else if (((r_cnt > 5'sd0) && (w_diff > 5'sd0)) ||
                             ((r_cnt < 5'sd0) && (w_diff < 5'sd0))) begin
                    w_tmds     = {1'b1, w_q8, ~r_q_m[7:0]};
                    w_cnt_next = r_cnt + (w_q8 ? 5'sd2 : 5'sd0) - w_diff;
                end else begin
                    w_tmds     = {1'b0, w_q8, r_q_m[7:0]};
                    w_cnt_next = r_cnt + w_diff - (w_q8 ? 5'sd0 : 5'sd2);
                end
            end
            MODE_ISLE: begin
`ifdef HDMI_TERC4_EN
                w_tmds = terc4_code(r_aux);
`else
                w_tmds = ctrl_code(r_ctrl);
`endif
            end
            MODE_GUARD: begin
                w_tmds = GUARD_CODE;
            end
            default: begin
                w_tmds = ctrl_code(r_ctrl);
            end
        endcase
    end

    always_ff @(posedge ref_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_q_m  <= '0;
            r_mode <= MODE_CTRL;
            r_ctrl <= 2'b00;
`ifdef HDMI_TERC4_EN
            r_aux  <= 4'h0;
`endif
            r_tmds <= RESET_CODE;
            r_cnt  <= 5'sd0;
        end else begin
            r_q_m  <= w_q_m;
            r_mode <= bus.mode_i;
            r_ctrl <= bus.ctrl_i;
`ifdef HDMI_TERC4_EN
            r_aux  <= bus.aux_i;
`endif
            r_tmds <= w_tmds;
            r_cnt  <= w_cnt_next;
        end
    end

    assign bus.tmds_o = r_tmds;

endmodule
